ram_2p_banked_handshake: RTL and testbench

// - Parametrised true dual-port, byte-addressable RAM built from BYTES 8-bit banks.
// - Supports unaligned word access and per-byte write enables.
// - Each port has a valid/ready request channel and a valid/ready response channel.
// - The read data path is registered.
// - Data memory shared by the vector processor core and its DMA/loader port.

---
 rtl/ram_2p_banked_handshake.sv | 146 ++++++++++++++
 tb/tb_ram_2p_banked_handshake.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ram_2p_banked_handshake.sv
// True dual-port byte-addressable RAM split across BYTES 8-bit banks, so that
// unaligned words are read and written in a single cycle with valid/ready handshakes.

module ram_2p_banked_bank #(
  parameter int    RA_W      = 16,
  parameter string INIT_PATH = "",
  parameter int    BANK      = 0
) (
  input  logic                 clock,
  input  logic [1:0]           en,
  input  logic [1:0]           we,
  input  logic [1:0][RA_W-1:0] row,
  input  logic [1:0][7:0]      wd,
  output logic [1:0][7:0]      rd
);
  logic [7:0] mem [2**RA_W];

  initial begin
    for (int i = 0; i < 2**RA_W; i++) mem[i] = 8'h00;
  end

  // Reads sample the old contents; port 1 is written last so it wins a row collision.
  always_ff @(posedge clock) begin
    if (en[0]) rd[0] <= mem[row[0]];
    if (en[1]) rd[1] <= mem[row[1]];
    if (we[1]) mem[row[1]] <= wd[1];
    if (we[0]) mem[row[0]] <= wd[0];
  end
endmodule

module ram_2p_banked_handshake #(
  parameter int    BYTES     = 4,
  parameter int    ADDR_W    = 18,
  parameter string INIT_PATH = ""
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid_1,
  output logic                req_ready_1,
  input  logic [ADDR_W-1:0]   address_1,
  input  logic                write_enable_1,
  input  logic [BYTES-1:0]    byte_enablers_1,
  input  logic [8*BYTES-1:0]  data_in_1,
  output logic                resp_valid_1,
  input  logic                resp_ready_1,
  output logic [8*BYTES-1:0]  data_out_1,
  input  logic                req_valid_2,
  output logic                req_ready_2,
  input  logic [ADDR_W-1:0]   address_2,
  input  logic                write_enable_2,
  input  logic [BYTES-1:0]    byte_enablers_2,
  input  logic [8*BYTES-1:0]  data_in_2,
  output logic                resp_valid_2,
  input  logic                resp_ready_2,
  output logic [8*BYTES-1:0]  data_out_2
);
  localparam int OFF_W = $clog2(BYTES);
  localparam int RA_W  = ADDR_W - OFF_W;

  logic [1:0]                   req_valid, req_ready, write_en, resp_ready, acc;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][BYTES-1:0]        be;
  logic [1:0][BYTES-1:0][7:0]   din, dout;
  logic [1:0]                   rsp_vld, rsp_rd;
  logic [1:0][OFF_W-1:0]        off_q;

  logic [1:0]                   bk_en  [BYTES];
  logic [1:0]                   bk_we  [BYTES];
  logic [1:0][RA_W-1:0]         bk_row [BYTES];
  logic [1:0][7:0]              bk_wd  [BYTES];
  logic [1:0][7:0]              bk_rd  [BYTES];

  assign req_valid  = {req_valid_2, req_valid_1};
  assign write_en   = {write_enable_2, write_enable_1};
  assign resp_ready = {resp_ready_2, resp_ready_1};
  assign addr       = {address_2, address_1};
  assign be         = {byte_enablers_2, byte_enablers_1};
  assign din        = {data_in_2, data_in_1};

  assign req_ready  = ~rsp_vld | resp_ready;
  assign acc        = req_valid & req_ready;

  assign req_ready_1  = req_ready[0];
  assign req_ready_2  = req_ready[1];
  assign resp_valid_1 = rsp_vld[0];
  assign resp_valid_2 = rsp_vld[1];
  assign data_out_1   = dout[0];
  assign data_out_2   = dout[1];

  // Word byte i lands on bank (off+i); banks below off belong to the next row.
  always_comb begin
    logic [OFF_W-1:0] lane;
    lane = '0;
    for (int b = 0; b < BYTES; b++) begin
      for (int p = 0; p < 2; p++) begin
        lane         = OFF_W'(b) - addr[p][OFF_W-1:0];
        bk_en[b][p]  = acc[p];
        bk_we[b][p]  = acc[p] & write_en[p] & be[p][lane];
        bk_wd[b][p]  = din[p][lane];
        bk_row[b][p] = addr[p][ADDR_W-1:OFF_W] + RA_W'(OFF_W'(b) < addr[p][OFF_W-1:0]);
      end
    end
  end

  for (genvar b = 0; b < BYTES; b++) begin : g_bank
    ram_2p_banked_bank #(.RA_W(RA_W), .INIT_PATH(INIT_PATH), .BANK(b)) u_bank (
      .clock (clock),
      .en    (bk_en[b]),
      .we    (bk_we[b]),
      .row   (bk_row[b]),
      .wd    (bk_wd[b]),
      .rd    (bk_rd[b])
    );
  end

  // Response state only advances when the port is not stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld <= '0;
      rsp_rd  <= '0;
      off_q   <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (req_ready[p]) begin
          rsp_vld[p] <= req_valid[p];
          if (req_valid[p]) begin
            rsp_rd[p] <= ~write_en[p];
            off_q[p]  <= addr[p][OFF_W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    logic [OFF_W-1:0] idx;
    idx  = '0;
    dout = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < BYTES; i++) begin
        idx = off_q[p] + OFF_W'(i);
        if (rsp_rd[p]) dout[p][i] = bk_rd[idx][p];
      end
    end
  end
endmodule

// File: tb/tb_ram_2p_banked_handshake.sv
// Randomized scoreboard bench for ram_2p_banked_handshake against a byte-array model.

module tb_ram_2p_banked_handshake;
  localparam int BYTES  = 4;
  localparam int ADDR_W = 18;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  typedef struct {
    logic              v;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [3:0]        be;
    logic [31:0]       d;
  } req_t;

  logic clock = 1'b0;
  logic reset_n;
  logic req_valid_1, req_ready_1, write_enable_1, resp_valid_1, resp_ready_1;
  logic req_valid_2, req_ready_2, write_enable_2, resp_valid_2, resp_ready_2;
  logic [ADDR_W-1:0] address_1, address_2;
  logic [3:0]  byte_enablers_1, byte_enablers_2;
  logic [31:0] data_in_1, data_in_2, data_out_1, data_out_2;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [2][$];
  logic [7:0]  mem_m [int];

  always #5 clock = ~clock;

  ram_2p_banked_handshake #(.BYTES(BYTES), .ADDR_W(ADDR_W), .INIT_PATH("")) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .address_1(address_1),
    .write_enable_1(write_enable_1), .byte_enablers_1(byte_enablers_1), .data_in_1(data_in_1),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1), .data_out_1(data_out_1),
    .req_valid_2(req_valid_2), .req_ready_2(req_ready_2), .address_2(address_2),
    .write_enable_2(write_enable_2), .byte_enablers_2(byte_enablers_2), .data_in_2(data_in_2),
    .resp_valid_2(resp_valid_2), .resp_ready_2(resp_ready_2), .data_out_2(data_out_2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int x);
    return mem_m.exists(x) ? mem_m[x] : 8'h00;
  endfunction

  function automatic logic [31:0] mrd(input int a);
    logic [31:0] r;
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = mbyte((a + i) & AMASK);
    return r;
  endfunction

  function automatic req_t mk(input logic v, input logic we, input int a, input logic [3:0] be,
                              input logic [31:0] d);
    req_t r;
    r.v = v; r.we = we; r.a = ADDR_W'(a); r.be = be; r.d = d;
    return r;
  endfunction

  // Issue one cycle of requests; expectations are pushed once acceptance is known.
  task automatic step(input req_t r1, input req_t r2);
    req_t        r   [2];
    logic [31:0] rdv [2];
    logic        acc [2];
    r[0] = r1; r[1] = r2;
    req_valid_1 = r1.v; write_enable_1 = r1.we; address_1 = r1.a;
    byte_enablers_1 = r1.be; data_in_1 = r1.d;
    req_valid_2 = r2.v; write_enable_2 = r2.we; address_2 = r2.a;
    byte_enablers_2 = r2.be; data_in_2 = r2.d;
    @(negedge clock); #1;
    for (int p = 0; p < 2; p++) begin
      acc[p] = r[p].v && (exp_q[p].size() == 0);
      rdv[p] = mrd(int'(r[p].a));
    end
    // Port 2 first so port 1 overwrites shared bytes.
    for (int p = 1; p >= 0; p--)
      if (acc[p] && r[p].we)
        for (int i = 0; i < BYTES; i++)
          if (r[p].be[i]) mem_m[(int'(r[p].a) + i) & AMASK] = r[p].d[8*i +: 8];
    for (int p = 0; p < 2; p++)
      if (acc[p]) exp_q[p].push_back(r[p].we ? 32'h0 : rdv[p]);
    @(posedge clock); #1;
  endtask

  task automatic mon_port(input int p, input logic rv, input logic rr, input logic rq,
                          input logic [31:0] d);
    bit pend;
    pend = exp_q[p].size() > 0;
    chk($sformatf("req_ready_%0d", p + 1), {31'b0, rq}, {31'b0, !(pend && !rr)});
    chk($sformatf("resp_valid_%0d", p + 1), {31'b0, rv}, {31'b0, pend});
    if (pend) begin
      chk($sformatf("data_out_%0d", p + 1), d, exp_q[p][0]);
      if (rr) void'(exp_q[p].pop_front());
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      mon_port(0, resp_valid_1, resp_ready_1, req_ready_1, data_out_1);
      mon_port(1, resp_valid_2, resp_ready_2, req_ready_2, data_out_2);
    end else begin
      exp_q[0].delete();
      exp_q[1].delete();
    end
  end

  function automatic int rnd_addr();
    return ($urandom_range(1) == 1) ? int'($urandom_range(31)) : AMASK - int'($urandom_range(7));
  endfunction

  initial begin
    req_t idle;
    idle = mk(0, 0, 0, 4'h0, 32'h0);
    reset_n = 1'b0;
    resp_ready_1 = 1'b1; resp_ready_2 = 1'b1;
    req_valid_1 = 0; write_enable_1 = 0; address_1 = '0; byte_enablers_1 = '0; data_in_1 = '0;
    req_valid_2 = 0; write_enable_2 = 0; address_2 = '0; byte_enablers_2 = '0; data_in_2 = '0;
    #2;
    chk("rst resp_valid_1", {31'b0, resp_valid_1}, 32'h0);
    chk("rst resp_valid_2", {31'b0, resp_valid_2}, 32'h0);
    chk("rst data_out_1", data_out_1, 32'h0);
    chk("rst data_out_2", data_out_2, 32'h0);
    chk("rst req_ready_1", {31'b0, req_ready_1}, 32'h1);
    chk("rst req_ready_2", {31'b0, req_ready_2}, 32'h1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic read of unwritten memory, then unaligned reads and top-row wrap.
    step(mk(1, 0, 0, 4'h0, 0), idle);
    step(mk(1, 1, 0, 4'hF, 32'hDDCCBBAA), idle);
    step(idle, mk(1, 0, 1, 4'h0, 0));
    step(idle, mk(1, 0, 3, 4'h0, 0));
    step(mk(1, 1, AMASK - 1, 4'hF, 32'h44332211), idle);
    step(idle, mk(1, 0, 0, 4'h0, 0));
    step(idle, mk(1, 0, AMASK - 1, 4'h0, 0));

    // Same-cycle collisions.
    step(mk(1, 1, 8, 4'h3, 32'h11111111), mk(1, 1, 8, 4'hF, 32'h22222222));
    step(mk(1, 0, 8, 4'h0, 0), idle);
    step(mk(1, 1, 8, 4'hF, 32'h33333333), mk(1, 0, 8, 4'h0, 0));
    step(idle, mk(1, 0, 8, 4'h0, 0));
    step(mk(1, 0, 6, 4'h0, 0), mk(1, 0, 6, 4'h0, 0));
    step(mk(1, 1, 9, 4'h0, 32'hFFFFFFFF), idle);
    step(mk(1, 0, 8, 4'h0, 0), idle);

    // Stall: write attempted while the response is held must not land.
    resp_ready_1 = 1'b0;
    step(mk(1, 0, 8, 4'h0, 0), idle);
    repeat (3) step(mk(1, 1, 8, 4'hF, 32'h55555555), idle);
    resp_ready_1 = 1'b1;
    step(mk(1, 0, 8, 4'h0, 0), idle);
    step(idle, idle);

    // Streaming reads, then reset in the middle of a stream.
    for (int k = 0; k < 16; k++) step(idle, mk(1, 0, k, 4'h0, 0));
    step(idle, idle);
    for (int k = 0; k < 4; k++) step(idle, mk(1, 0, AMASK - k, 4'h0, 0));
    reset_n = 1'b0;
    #1;
    chk("midrst resp_valid_2", {31'b0, resp_valid_2}, 32'h0);
    chk("midrst data_out_2", data_out_2, 32'h0);
    req_valid_1 = 1'b0; req_valid_2 = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Random traffic on both ports with random response back-pressure.
    for (int k = 0; k < 400; k++) begin
      resp_ready_1 = ($urandom_range(3) != 0);
      resp_ready_2 = ($urandom_range(3) != 0);
      step(mk($urandom_range(3) != 0, $urandom_range(1) == 1, rnd_addr(),
              4'($urandom_range(15)), $urandom),
           mk($urandom_range(3) != 0, $urandom_range(1) == 1, rnd_addr(),
              4'($urandom_range(15)), $urandom));
    end
    resp_ready_1 = 1'b1; resp_ready_2 = 1'b1;
    repeat (3) step(idle, idle);
    chk("drain q1", exp_q[0].size(), 32'h0);
    chk("drain q2", exp_q[1].size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
